// File: rtl/axil_reg_slice_if.sv
// +--------------------------------------------------------------------------+
// | axil_pkg / axil_if : AXI-Lite widths and five-channel bundle with        |
// | slave-side (s_axil) and master-side (m_axil) modports.   Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

package axil_pkg;
  parameter int AXI_ADDR_WIDTH = 32;
  parameter int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
endpackage

interface axil_if;
  import axil_pkg::*;

  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [AXI_STRB_WIDTH-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport s_axil (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport m_axil (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
endinterface

`default_nettype wire

// File: rtl/axil_reg_slice.sv
// +--------------------------------------------------------------------------+
// | axil_reg_slice : per-channel AXI-Lite register slice. AXIL_SLICE_FULL_BW_EN|
// | selects skid-buffer stages; otherwise single-register stages. Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module axil_slice_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef AXIL_SLICE_FULL_BW_EN
  localparam logic [1:0] ST_FULL  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             in_hs;
  logic             out_hs;

  assign in_hs  = valid_i & ready_q;
  assign out_hs = valid_q & ready_i;

`ifdef AXIL_SLICE_FULL_BW_EN
  logic [WIDTH-1:0] skid_q, skid_d;

  always_ff @(posedge aclk) begin
    if (!aresetn) skid_q <= '0;
    else          skid_q <= skid_d;
  end
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      main_q  <= main_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_hs) state_d = ST_ONE;
`ifdef AXIL_SLICE_FULL_BW_EN
      ST_ONE: begin
        if (in_hs && !out_hs)      state_d = ST_FULL;
        else if (!in_hs && out_hs) state_d = ST_EMPTY;
      end
      ST_FULL:  if (out_hs) state_d = ST_ONE;
`else
      ST_ONE:   if (out_hs) state_d = ST_EMPTY;
`endif
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Ready and valid are flopped copies of the next-state decode.
  always_comb begin
    main_d = main_q;
`ifdef AXIL_SLICE_FULL_BW_EN
    skid_d = skid_q;
`endif
    case (state_q)
      ST_EMPTY: if (in_hs) main_d = data_i;
`ifdef AXIL_SLICE_FULL_BW_EN
      ST_ONE: begin
        if (in_hs && out_hs) main_d = data_i;
        else if (in_hs)      skid_d = data_i;
      end
      ST_FULL:  if (out_hs) main_d = skid_q;
`endif
      default: ;
    endcase
    valid_d = (state_d != ST_EMPTY);
`ifdef AXIL_SLICE_FULL_BW_EN
    ready_d = (state_d != ST_FULL);
`else
    ready_d = (state_d == ST_EMPTY);
`endif
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign data_o  = main_q;
endmodule

module axil_reg_slice
  import axil_pkg::*;
#(
  parameter int unsigned AW_SLICE = 1,
  parameter int unsigned W_SLICE  = 1,
  parameter int unsigned B_SLICE  = 1,
  parameter int unsigned AR_SLICE = 1,
  parameter int unsigned R_SLICE  = 1
) (
  input  logic   aclk,
  input  logic   aresetn,
  axil_if.s_axil s_axil,
  axil_if.m_axil m_axil
);
  localparam int W_WIDTH = AXI_DATA_WIDTH + AXI_STRB_WIDTH;
  localparam int R_WIDTH = AXI_DATA_WIDTH + 2;

  if (AW_SLICE != 0) begin : g_aw_slice
    axil_slice_stage #(.WIDTH(AXI_ADDR_WIDTH)) u_stage (
      .aclk    (aclk),
      .aresetn (aresetn),
      .valid_i (s_axil.awvalid),
      .data_i  (s_axil.awaddr),
      .ready_o (s_axil.awready),
      .valid_o (m_axil.awvalid),
      .data_o  (m_axil.awaddr),
      .ready_i (m_axil.awready)
    );
  end else begin : g_aw_bypass
    assign m_axil.awvalid = s_axil.awvalid;
    assign m_axil.awaddr  = s_axil.awaddr;
    assign s_axil.awready = m_axil.awready;
  end

  if (W_SLICE != 0) begin : g_w_slice
    logic [W_WIDTH-1:0] w_up_data;
    logic [W_WIDTH-1:0] w_dn_data;
    assign w_up_data = {s_axil.wstrb, s_axil.wdata};
    assign {m_axil.wstrb, m_axil.wdata} = w_dn_data;
    axil_slice_stage #(.WIDTH(W_WIDTH)) u_stage (
      .aclk    (aclk),
      .aresetn (aresetn),
      .valid_i (s_axil.wvalid),
      .data_i  (w_up_data),
      .ready_o (s_axil.wready),
      .valid_o (m_axil.wvalid),
      .data_o  (w_dn_data),
      .ready_i (m_axil.wready)
    );
  end else begin : g_w_bypass
    assign m_axil.wvalid = s_axil.wvalid;
    assign m_axil.wdata  = s_axil.wdata;
    assign m_axil.wstrb  = s_axil.wstrb;
    assign s_axil.wready = m_axil.wready;
  end

  if (B_SLICE != 0) begin : g_b_slice
    axil_slice_stage #(.WIDTH(2)) u_stage (
      .aclk    (aclk),
      .aresetn (aresetn),
      .valid_i (m_axil.bvalid),
      .data_i  (m_axil.bresp),
      .ready_o (m_axil.bready),
      .valid_o (s_axil.bvalid),
      .data_o  (s_axil.bresp),
      .ready_i (s_axil.bready)
    );
  end else begin : g_b_bypass
    assign s_axil.bvalid = m_axil.bvalid;
    assign s_axil.bresp  = m_axil.bresp;
    assign m_axil.bready = s_axil.bready;
  end

  if (AR_SLICE != 0) begin : g_ar_slice
    axil_slice_stage #(.WIDTH(AXI_ADDR_WIDTH)) u_stage (
      .aclk    (aclk),
      .aresetn (aresetn),
      .valid_i (s_axil.arvalid),
      .data_i  (s_axil.araddr),
      .ready_o (s_axil.arready),
      .valid_o (m_axil.arvalid),
      .data_o  (m_axil.araddr),
      .ready_i (m_axil.arready)
    );
  end else begin : g_ar_bypass
    assign m_axil.arvalid = s_axil.arvalid;
    assign m_axil.araddr  = s_axil.araddr;
    assign s_axil.arready = m_axil.arready;
  end

  if (R_SLICE != 0) begin : g_r_slice
    logic [R_WIDTH-1:0] w_up_data;
    logic [R_WIDTH-1:0] w_dn_data;
    assign w_up_data = {m_axil.rresp, m_axil.rdata};
    assign {s_axil.rresp, s_axil.rdata} = w_dn_data;
    axil_slice_stage #(.WIDTH(R_WIDTH)) u_stage (
      .aclk    (aclk),
      .aresetn (aresetn),
      .valid_i (m_axil.rvalid),
      .data_i  (w_up_data),
      .ready_o (m_axil.rready),
      .valid_o (s_axil.rvalid),
      .data_o  (w_dn_data),
      .ready_i (s_axil.rready)
    );
  end else begin : g_r_bypass
    assign s_axil.rvalid = m_axil.rvalid;
    assign s_axil.rdata  = m_axil.rdata;
    assign s_axil.rresp  = m_axil.rresp;
    assign m_axil.rready = s_axil.rready;
  end
endmodule

`default_nettype wire

// File: tb/tb_axil_reg_slice.sv
// +--------------------------------------------------------------------------+
// | tb_axil_reg_slice : scoreboard bench for axil_reg_slice (all channels    |
// | sliced) plus a W-bypass instance.                          Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_axil_reg_slice;
  import axil_pkg::*;

  localparam int NCH = 5;
  localparam int CH_AW = 0, CH_W = 1, CH_B = 2, CH_AR = 3, CH_R = 4;
`ifdef AXIL_SLICE_FULL_BW_EN
  localparam bit FULL_BW = 1'b1;
`else
  localparam bit FULL_BW = 1'b0;
`endif

  typedef logic [63:0] pl_t;
  typedef struct { pl_t data; int cyc; } exp_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic rst_q = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= aresetn;
  end

  axil_if s_if ();
  axil_if m_if ();
  axil_if s2_if ();
  axil_if m2_if ();

  axil_reg_slice dut (.aclk(clk), .aresetn(aresetn), .s_axil(s_if), .m_axil(m_if));
  axil_reg_slice #(.W_SLICE(0)) dut_byp (.aclk(clk), .aresetn(aresetn), .s_axil(s2_if), .m_axil(m2_if));

  // Channel-generic view: "up" is the source side, "dn" the sink side.
  logic [NCH-1:0] up_valid, up_ready, dn_valid, dn_ready;
  pl_t up_data [NCH];
  pl_t dn_data [NCH];

  assign s_if.awvalid = up_valid[CH_AW];
  assign s_if.awaddr  = up_data[CH_AW][AXI_ADDR_WIDTH-1:0];
  assign up_ready[CH_AW] = s_if.awready;
  assign dn_valid[CH_AW] = m_if.awvalid;
  assign dn_data[CH_AW]  = pl_t'(m_if.awaddr);
  assign m_if.awready = dn_ready[CH_AW];

  assign s_if.wvalid = up_valid[CH_W];
  assign {s_if.wstrb, s_if.wdata} = up_data[CH_W][AXI_DATA_WIDTH+AXI_STRB_WIDTH-1:0];
  assign up_ready[CH_W] = s_if.wready;
  assign dn_valid[CH_W] = m_if.wvalid;
  assign dn_data[CH_W]  = pl_t'({m_if.wstrb, m_if.wdata});
  assign m_if.wready = dn_ready[CH_W];

  assign m_if.bvalid = up_valid[CH_B];
  assign m_if.bresp  = up_data[CH_B][1:0];
  assign up_ready[CH_B] = m_if.bready;
  assign dn_valid[CH_B] = s_if.bvalid;
  assign dn_data[CH_B]  = pl_t'(s_if.bresp);
  assign s_if.bready = dn_ready[CH_B];

  assign s_if.arvalid = up_valid[CH_AR];
  assign s_if.araddr  = up_data[CH_AR][AXI_ADDR_WIDTH-1:0];
  assign up_ready[CH_AR] = s_if.arready;
  assign dn_valid[CH_AR] = m_if.arvalid;
  assign dn_data[CH_AR]  = pl_t'(m_if.araddr);
  assign m_if.arready = dn_ready[CH_AR];

  assign m_if.rvalid = up_valid[CH_R];
  assign {m_if.rresp, m_if.rdata} = up_data[CH_R][AXI_DATA_WIDTH+1:0];
  assign up_ready[CH_R] = m_if.rready;
  assign dn_valid[CH_R] = s_if.rvalid;
  assign dn_data[CH_R]  = pl_t'({s_if.rresp, s_if.rdata});
  assign s_if.rready = dn_ready[CH_R];

  // Bypass instance sees the same stimulus; only its W channel is checked.
  assign s2_if.awvalid = up_valid[CH_AW];
  assign s2_if.awaddr  = up_data[CH_AW][AXI_ADDR_WIDTH-1:0];
  assign m2_if.awready = dn_ready[CH_AW];
  assign s2_if.wvalid  = up_valid[CH_W];
  assign {s2_if.wstrb, s2_if.wdata} = up_data[CH_W][AXI_DATA_WIDTH+AXI_STRB_WIDTH-1:0];
  assign m2_if.wready  = dn_ready[CH_W];
  assign m2_if.bvalid  = up_valid[CH_B];
  assign m2_if.bresp   = up_data[CH_B][1:0];
  assign s2_if.bready  = dn_ready[CH_B];
  assign s2_if.arvalid = up_valid[CH_AR];
  assign s2_if.araddr  = up_data[CH_AR][AXI_ADDR_WIDTH-1:0];
  assign m2_if.arready = dn_ready[CH_AR];
  assign m2_if.rvalid  = up_valid[CH_R];
  assign {m2_if.rresp, m2_if.rdata} = up_data[CH_R][AXI_DATA_WIDTH+1:0];
  assign s2_if.rready  = dn_ready[CH_R];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int c, input pl_t act, input pl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0h, expected %0h (cycle %0d)", name, c, act, exp, cyc);
    end
  endtask

  function automatic pl_t pl_mask(input int c);
    case (c)
      CH_AW, CH_AR: return (pl_t'(1) << AXI_ADDR_WIDTH) - 1;
      CH_W:         return (pl_t'(1) << (AXI_DATA_WIDTH + AXI_STRB_WIDTH)) - 1;
      CH_B:         return pl_t'(3);
      default:      return (pl_t'(1) << (AXI_DATA_WIDTH + 2)) - 1;
    endcase
  endfunction

  pl_t  stim_q [NCH][$];
  exp_t exp_q  [NCH][$];
  int   acc_log [$];
  logic [NCH-1:0] hs_in = '0, hs_out = '0, hold_v = '0;
  pl_t  hold_d  [NCH];
  pl_t  last_dn [NCH];
  int   acc_cnt [NCH];
  int   dlv_cnt [NCH];
  bit   gap_en = 0, rnd_rdy = 0, tog_rdy = 0, lat_chk = 1;

  // Source driver: presents queued payloads, holds valid until accepted.
  initial begin
    up_valid = '0;
    dn_ready = '1;
    for (int c = 0; c < NCH; c++) up_data[c] = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) begin
        if (up_valid[c] && hs_in[c]) up_valid[c] = 1'b0;
        if (!up_valid[c] && stim_q[c].size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          up_data[c]  = stim_q[c].pop_front();
          up_valid[c] = 1'b1;
        end
        if (rnd_rdy) dn_ready[c] = ($urandom_range(0, 2) != 0);
      end
      if (tog_rdy) begin
        dn_ready[CH_B] = ~dn_ready[CH_B];
        dn_ready[CH_R] = ~dn_ready[CH_R];
      end
    end
  end

  // Monitor/scoreboard: inputs are stable at the falling edge, so the
  // handshakes seen here are the ones the next rising edge completes.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      hs_in[c]  = aresetn && up_valid[c] && up_ready[c];
      hs_out[c] = aresetn && dn_valid[c] && dn_ready[c];
      if (!rst_q) begin
        chk("reset_valid", c, pl_t'(dn_valid[c]), 0);
        chk("reset_ready", c, pl_t'(up_ready[c]), 0);
        chk("reset_data", c, dn_data[c], 0);
      end
      if (!aresetn) begin
        exp_q[c].delete();
        hold_v[c] = 1'b0;
      end else begin
        if (hold_v[c]) begin
          chk("valid_hold", c, pl_t'(dn_valid[c]), 1);
          chk("data_hold", c, dn_data[c], hold_d[c]);
        end
        if (hs_in[c]) begin
          exp_q[c].push_back('{data: up_data[c] & pl_mask(c), cyc: cyc});
          acc_cnt[c]++;
          if (c == CH_AW) acc_log.push_back(cyc);
        end
        if (hs_out[c]) begin
          dlv_cnt[c]++;
          last_dn[c] = dn_data[c];
          if (exp_q[c].size() == 0) begin
            chk("unexpected_transfer", c, dn_data[c], 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q[c].pop_front();
            chk("payload", c, dn_data[c], e.data);
            if (lat_chk) chk("latency", c, pl_t'(cyc), pl_t'(e.cyc + 1));
          end
        end
        hold_v[c] = dn_valid[c] && !dn_ready[c];
        hold_d[c] = dn_data[c];
      end
    end
    if (aresetn) begin
      chk("bypass_wvalid", CH_W, pl_t'(m2_if.wvalid), pl_t'(up_valid[CH_W]));
      chk("bypass_wpayload", CH_W, pl_t'({m2_if.wstrb, m2_if.wdata}), up_data[CH_W] & pl_mask(CH_W));
      chk("bypass_wready", CH_W, pl_t'(s2_if.wready), pl_t'(dn_ready[CH_W]));
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic tick_chk();
    @(negedge clk); #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick_chk();
      done = (up_valid == '0);
      for (int c = 0; c < NCH; c++)
        if (stim_q[c].size() != 0 || exp_q[c].size() != 0) done = 0;
    end
    chk("drain_within_budget", 0, pl_t'(done), 1);
  endtask

  initial begin
    int a0, d0;
    for (int c = 0; c < NCH; c++) begin
      acc_cnt[c] = 0; dlv_cnt[c] = 0; last_dn[c] = '0; hold_d[c] = '0;
    end

    // Reset with every source presenting a transfer.
    stim_q[CH_AW].push_back(64'hF00);
    stim_q[CH_W].push_back(64'h3_5555_0000);
    stim_q[CH_B].push_back(64'h1);
    stim_q[CH_AR].push_back(64'hF04);
    stim_q[CH_R].push_back(64'h1_0000_1234);
    repeat (4) step();
    aresetn = 1'b1;
    tick_chk();
    tick_chk();
    for (int c = 0; c < NCH; c++) chk("ready_after_release", c, pl_t'(up_ready[c]), 1);
    wait_drain(50);

    // Streaming writes with downstream always ready.
    acc_log.delete();
    for (int i = 0; i < 8; i++) begin
      stim_q[CH_AW].push_back(pl_t'(i * 4));
      stim_q[CH_W].push_back(64'hF_0000_0000 | pl_t'(32'hA0 + i));
    end
    wait_drain(100);
    chk("aw_accepts", CH_AW, pl_t'(acc_log.size()), 8);
    if (acc_log.size() == 8)
      chk("aw_throughput_span", CH_AW, pl_t'(acc_log[7] - acc_log[0]), FULL_BW ? 7 : 14);

    // Back-pressure on AR.
    lat_chk = 0;
    step();
    dn_ready[CH_AR] = 1'b0;
    a0 = acc_cnt[CH_AR];
    stim_q[CH_AR].push_back(64'h100);
    stim_q[CH_AR].push_back(64'h104);
    stim_q[CH_AR].push_back(64'h108);
    repeat (5) tick_chk();
    chk("ar_absorbed", CH_AR, pl_t'(acc_cnt[CH_AR] - a0), FULL_BW ? 2 : 1);
    chk("ar_ready_stalled", CH_AR, pl_t'(up_ready[CH_AR]), 0);
    step();
    dn_ready[CH_AR] = 1'b1;
    wait_drain(50);
    chk("ar_last_delivered", CH_AR, last_dn[CH_AR], 64'h108);

    // Response path with toggling upstream ready.
    tog_rdy = 1;
    stim_q[CH_R].push_back({30'h0, 2'b10, 32'hDEAD_BEEF});
    stim_q[CH_B].push_back(64'h0);
    wait_drain(50);
    chk("r_delivered", CH_R, last_dn[CH_R], 64'h2_DEAD_BEEF);
    chk("b_delivered", CH_B, last_dn[CH_B], 64'h0);
    tog_rdy = 0;
    step();
    dn_ready = '1;

    // Bypass: W payload appears downstream in the same cycle.
    stim_q[CH_W].push_back(64'hF_1234_5678);
    tick_chk();
    tick_chk();
    chk("bypass_same_cycle_wdata", CH_W, pl_t'(m2_if.wdata), 64'h1234_5678);
    chk("bypass_same_cycle_wvalid", CH_W, pl_t'(m2_if.wvalid), 1);
    wait_drain(50);

    // Randomized traffic on all channels.
    gap_en = 1;
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++)
      for (int c = 0; c < NCH; c++)
        stim_q[c].push_back({$urandom, $urandom} & pl_mask(c));
    wait_drain(3000);
    gap_en = 0;
    rnd_rdy = 0;
    step();
    dn_ready = '1;
    tick_chk();

    // Reset while AW holds buffered addresses.
    step();
    dn_ready[CH_AW] = 1'b0;
    a0 = acc_cnt[CH_AW];
    stim_q[CH_AW].push_back(64'h200);
    stim_q[CH_AW].push_back(64'h204);
    repeat (4) tick_chk();
    chk("aw_buffered", CH_AW, pl_t'(acc_cnt[CH_AW] - a0), FULL_BW ? 2 : 1);
    step();
    aresetn = 1'b0;
    d0 = dlv_cnt[CH_AW];
    repeat (2) step();
    aresetn = 1'b1;
    dn_ready[CH_AW] = 1'b1;
    wait_drain(50);
    chk("aw_after_reset_deliveries", CH_AW, pl_t'(dlv_cnt[CH_AW] - d0), FULL_BW ? 0 : 1);

    for (int c = 0; c < NCH; c++) chk("scoreboard_empty", c, pl_t'(exp_q[c].size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

`default_nettype wire
